// File: rtl/recibir_pkg.sv
// +----------------------------------------------------------------------------+
// | recibir_pkg : shared FSM encoding, baud divisors and ASCII digit bounds    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package recibir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Clock cycles per bit at 50 MHz, identical to the transmit stage divisors
  localparam int B115200 = 434;
  localparam int B57600  = 868;
  localparam int B38400  = 1302;
  localparam int B19200  = 2604;
  localparam int B9600   = 5208;
  localparam int B4800   = 10417;
  localparam int B2400   = 20833;
  localparam int B1200   = 41667;
  localparam int B600    = 83333;
  localparam int B300    = 166667;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  function automatic logic [3:0] sat_inc10(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd10 : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +----------------------------------------------------------------------------+
// | uart_rx_core : 8N1 receiver - synchronizer, bit timer, FSM, shift register |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
  import recibir_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] c_half = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(BAUD - 1);

  logic          r_rx_meta;
  logic          r_rx_s;
  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;

  logic w_tick;
  logic w_load_half;
  logic w_load_full;
  logic w_shift;
  logic w_valid_set;
  logic w_ferr_set;

  assign w_tick = (r_cnt == '0);

  // Both stages reset to the idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift     = 1'b0;
    w_valid_set = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_load_half = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_load_full = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift     = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_valid_set = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The bit index wraps to 0 after the eighth shift, so every frame starts at bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_valid_set;
      r_frame_err <= w_ferr_set;
      if (w_load_half)      r_cnt <= c_half;
      else if (w_load_full) r_cnt <= c_full;
      else if (!w_tick)     r_cnt <= r_cnt - 1'b1;
      if (w_shift) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_valid_set) r_data <= r_shift;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/recibir_datos.sv
// +----------------------------------------------------------------------------+
// | recibir_datos : UART receiver with optional '0'..'9' sequence checker      |
// | Sequence checker compiled in with RECIBIR_SEQ_CHECK_EN.  Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module recibir_datos
  import recibir_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       seq_err,
  output logic [3:0] digit_count,
  output logic       done
);

  uart_rx_core #(
    .BAUD(BAUD)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err)
  );

`ifdef RECIBIR_SEQ_CHECK_EN
  logic [7:0] r_expected;
  logic [3:0] r_digit_count;
  logic       r_done;
  logic       r_seq_err;

  // Once '9' is accepted the expected byte stays at '9'; done alone rejects later bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected    <= ASCII_0;
      r_digit_count <= 4'd0;
      r_done        <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_seq_err <= 1'b0;
      if (valid) begin
        if ((data == r_expected) && !r_done) begin
          r_digit_count <= sat_inc10(r_digit_count);
          if (data == ASCII_9) r_done     <= 1'b1;
          else                 r_expected <= r_expected + 8'd1;
        end else begin
          r_seq_err <= 1'b1;
        end
      end
    end
  end

  assign seq_err     = r_seq_err;
  assign digit_count = r_digit_count;
  assign done        = r_done;
`else
  assign seq_err     = 1'b0;
  assign digit_count = 4'd0;
  assign done        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_recibir_datos.sv
// +----------------------------------------------------------------------------+
// | tb_recibir_datos : directed bench, slow (434) and fast (32) baud instances |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_recibir_datos;

  localparam int BAUD_S = 434;
  localparam int BAUD_F = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_slow;
  logic       rx_fast;

  logic [7:0] s_data, f_data;
  logic       s_valid, f_valid, s_ferr, f_ferr, s_seq, f_seq, s_done, f_done;
  logic [3:0] s_dc, f_dc;

  int n_checks = 0;
  int n_fail   = 0;

  recibir_datos #(.BAUD(BAUD_S)) u_slow (
    .clk(clk), .rst(rst), .rx(rx_slow), .data(s_data), .valid(s_valid),
    .frame_err(s_ferr), .seq_err(s_seq), .digit_count(s_dc), .done(s_done)
  );

  recibir_datos #(.BAUD(BAUD_F)) u_fast (
    .clk(clk), .rst(rst), .rx(rx_fast), .data(f_data), .valid(f_valid),
    .frame_err(f_ferr), .seq_err(f_seq), .digit_count(f_dc), .done(f_done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  int s_vcnt = 0, s_fcnt = 0, s_scnt = 0, s_vcyc = 0;
  int f_vcnt = 0, f_fcnt = 0, f_scnt = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid) begin
      s_vcnt <= s_vcnt + 1;
      s_vcyc <= cyc;
    end
    if (s_ferr)  s_fcnt <= s_fcnt + 1;
    if (s_seq)   s_scnt <= s_scnt + 1;
    if (f_valid) f_vcnt <= f_vcnt + 1;
    if (f_ferr)  f_fcnt <= f_fcnt + 1;
    if (f_seq)   f_scnt <= f_scnt + 1;
    if ((s_valid && s_ferr) || (f_valid && f_ferr)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit fast, input logic v);
    if (fast) rx_fast = v;
    else      rx_slow = v;
  endtask

  task automatic send_frame(input bit fast, input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    int         baud;
    baud = fast ? BAUD_F : BAUD_S;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(fast, bits[i]);
      wait_cyc(baud);
    end
  endtask

  task automatic reset_all();
    rst     = 1'b1;
    rx_slow = 1'b1;
    rx_fast = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    int v0, f0, sc0, p;
    logic [9:0] pbits;

    rst     = 1'b1;
    rx_slow = 1'b1;
    rx_fast = 1'b1;
    @(negedge clk);
    reset_all();
    check("reset_slow", 32'({s_data, s_valid, s_ferr, s_seq, s_done, s_dc}), 32'h0);
    check("reset_fast", 32'({f_data, f_valid, f_ferr, f_seq, f_done, f_dc}), 32'h0);

    // Single frame at BAUD=434 with pin-to-valid latency
    v0 = s_vcnt; f0 = s_fcnt; p = cyc;
    send_frame(1'b0, 8'h35, 1'b1);
    wait_cyc(BAUD_S);
    check("single_valid_count", 32'(s_vcnt - v0), 32'd1);
    check("single_latency", 32'(s_vcyc - p), 32'(3 + BAUD_S / 2 + 9 * BAUD_S));
    check("single_data", 32'(s_data), 32'h35);
    check("single_no_ferr", 32'(s_fcnt - f0), 32'd0);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("single_seq_err", 32'(s_scnt), 32'd1);
`else
    check("single_seq_off", 32'(s_scnt), 32'd0);
`endif

    // Short low glitch is rejected at the start-bit sample
    v0 = s_vcnt; f0 = s_fcnt;
    rx_slow = 1'b0;
    wait_cyc(100);
    rx_slow = 1'b1;
    wait_cyc(600);
    check("glitch_no_valid", 32'(s_vcnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(s_fcnt - f0), 32'd0);
    send_frame(1'b0, 8'h36, 1'b1);
    wait_cyc(BAUD_S);
    check("glitch_next_valid", 32'(s_vcnt - v0), 32'd1);
    check("glitch_next_data", 32'(s_data), 32'h36);

    // Full '0'..'9' sequence back-to-back, then an extra '0'
    reset_all();
    v0 = f_vcnt; sc0 = f_scnt;
    for (int i = 0; i < 10; i++) send_frame(1'b1, 8'(8'h30 + i), 1'b1);
    wait_cyc(BAUD_F);
    check("seq_valid_count", 32'(f_vcnt - v0), 32'd10);
    check("seq_last_data", 32'(f_data), 32'h39);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("seq_digit_count", 32'(f_dc), 32'd10);
    check("seq_done", 32'(f_done), 32'd1);
    check("seq_no_err", 32'(f_scnt - sc0), 32'd0);
`else
    check("seq_off_outputs", 32'({f_dc, f_done}), 32'd0);
`endif
    send_frame(1'b1, 8'h30, 1'b1);
    wait_cyc(BAUD_F);
    check("extra_valid_count", 32'(f_vcnt - v0), 32'd11);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("extra_seq_err", 32'(f_scnt - sc0), 32'd1);
    check("extra_digit_sat", 32'(f_dc), 32'd10);
    check("extra_done_sticky", 32'(f_done), 32'd1);
`else
    check("extra_seq_off", 32'(f_scnt - sc0), 32'd0);
`endif

    // Framing error with line held low, then recovery
    reset_all();
    send_frame(1'b1, 8'h30, 1'b1);
    wait_cyc(BAUD_F);
    check("frame_pre_data", 32'(f_data), 32'h30);
    v0 = f_vcnt; f0 = f_fcnt;
    send_frame(1'b1, 8'hA5, 1'b0);
    wait_cyc(20 * BAUD_F);
    rx_fast = 1'b1;
    wait_cyc(2 * BAUD_F);
    check("frame_err_count", 32'(f_fcnt - f0), 32'd1);
    check("frame_no_valid", 32'(f_vcnt - v0), 32'd0);
    check("frame_data_kept", 32'(f_data), 32'h30);
    send_frame(1'b1, 8'h31, 1'b1);
    wait_cyc(BAUD_F);
    check("frame_recover_data", 32'(f_data), 32'h31);
    check("frame_recover_valid", 32'(f_vcnt - v0), 32'd1);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("frame_recover_digits", 32'(f_dc), 32'd2);
`else
    check("frame_recover_digits_off", 32'(f_dc), 32'd0);
`endif

    // Reset asserted during data bit 4 of a frame
    reset_all();
    v0 = f_vcnt; f0 = f_fcnt;
    pbits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rx_fast = pbits[i];
      wait_cyc((i == 5) ? BAUD_F / 2 : BAUD_F);
    end
    rst     = 1'b1;
    rx_fast = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2 * BAUD_F);
    check("midrst_no_valid", 32'(f_vcnt - v0), 32'd0);
    check("midrst_no_ferr", 32'(f_fcnt - f0), 32'd0);
    check("midrst_data", 32'(f_data), 32'h00);
    send_frame(1'b1, 8'h30, 1'b1);
    wait_cyc(BAUD_F);
    check("midrst_next_valid", 32'(f_vcnt - v0), 32'd1);
    check("midrst_next_data", 32'(f_data), 32'h30);

    // Out-of-sequence byte
    reset_all();
    sc0 = f_scnt;
    send_frame(1'b1, 8'h30, 1'b1);
    send_frame(1'b1, 8'h32, 1'b1);
    wait_cyc(BAUD_F);
    check("seqerr_data", 32'(f_data), 32'h32);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("seqerr_pulse", 32'(f_scnt - sc0), 32'd1);
    check("seqerr_digits_hold", 32'(f_dc), 32'd1);
`else
    check("seqerr_off", 32'(f_scnt - sc0), 32'd0);
`endif
    send_frame(1'b1, 8'h31, 1'b1);
    wait_cyc(BAUD_F);
    check("seqerr_resume_data", 32'(f_data), 32'h31);
`ifdef RECIBIR_SEQ_CHECK_EN
    check("seqerr_resume_digits", 32'(f_dc), 32'd2);
    check("seqerr_no_new_err", 32'(f_scnt - sc0), 32'd1);
`else
    check("seqerr_resume_off", 32'({f_dc, f_done}), 32'd0);
`endif

    check("valid_ferr_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
